// File: rtl/qspi_mem_model.sv
// Oversampled QSPI memory target: NCS devices of DEPTH bytes each, 0x03 / 0xEB reads,
// optional 0x38 quad write when QSPI_MEM_WRITE_EN is defined, plus a backdoor preload port.
`timescale 1ns/1ps
module qspi_mem_model #(
    parameter int NCS   = 2,
    parameter int DEPTH = 65536,
    parameter int AW    = 24,
    parameter int DUMMY = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_in,
    input  logic                     sck_i,
    input  logic [NCS-1:0]           cs_in,
    input  logic [3:0]               sdi_i,
    output logic [3:0]               sdo_o,
    output logic [3:0]               sdo_oe_o,
    input  logic                     bd_we_i,
    input  logic [$clog2(NCS)-1:0]   bd_sel_i,
    input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
    input  logic [7:0]               bd_data_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int SW = $clog2(NCS);
    localparam int DW = $clog2(DEPTH);
    localparam logic [7:0] ADDR_LAST_S = 8'(AW - 1);
    localparam logic [7:0] ADDR_LAST_Q = 8'(AW / 4 - 1);
    localparam logic [7:0] DUMMY_LAST  = 8'(DUMMY - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    state_t          state_r, state_s;
    logic [7:0]      mem_r [NCS][DEPTH];
    logic            sck_q_r;
    logic            rise_s, fall_s, act_s, rise_v, fall_v;
    logic [7:0]      low_cnt_s;
    logic [SW-1:0]   low_idx_s;
    logic [SW-1:0]   sel_r, sel_s;
    logic [6:0]      cmd_r, cmd_s;
    logic [7:0]      cmd_next_s;
    logic            op_ok_s, op_quad_s, op_write_s;
    logic [7:0]      cnt_r, cnt_s, addr_last_s;
    logic [DW-1:0]   addr_r, addr_s;
    logic [2:0]      dcnt_r, dcnt_s;
    logic [3:0]      wnib_r, wnib_s;
    logic            quad_r, quad_s, write_r, write_s;
    logic [3:0]      drv_sdo_r, drv_sdo_s, drv_oe_r, drv_oe_s;
    logic            drv_pend_r, drv_pend_s;
    logic            err_r, err_set_s;
    logic            mem_we_s;
    logic [7:0]      mem_wdata_s, rd_byte_s;
    logic [3:0]      sdo_r, oe_r;
    logic            busy_r;

    // sck edge detector; edges are only honoured while the latched device stays selected
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            sck_q_r <= 1'b0;
        end else begin
            sck_q_r <= sck_i;
        end
    end

    assign rise_s = sck_i & ~sck_q_r;
    assign fall_s = ~sck_i & sck_q_r;
    assign act_s  = (state_r != ST_IDLE) && !cs_in[sel_r];
    assign rise_v = rise_s & act_s;
    assign fall_v = fall_s & act_s;
    assign rd_byte_s   = mem_r[sel_r][addr_r];
    assign addr_last_s = quad_r ? ADDR_LAST_Q : ADDR_LAST_S;

    // Chip-select census: number of asserted selects and the lowest asserted index
    always_comb begin
        low_cnt_s = 8'd0;
        low_idx_s = '0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if (!cs_in[i]) begin
                low_cnt_s = low_cnt_s + 8'd1;
                low_idx_s = SW'(i);
            end else begin
                low_cnt_s = low_cnt_s;
            end
        end
    end

    // Opcode decode of the byte completed by the current io0 bit
    always_comb begin
        cmd_next_s = {cmd_r, sdi_i[0]};
        op_ok_s    = 1'b1;
        op_quad_s  = 1'b0;
        op_write_s = 1'b0;
        case (cmd_next_s)
            8'h03: op_quad_s = 1'b0;
            8'hEB: op_quad_s = 1'b1;
`ifdef QSPI_MEM_WRITE_EN
            8'h38: begin
                op_quad_s  = 1'b1;
                op_write_s = 1'b1;
            end
`endif
            default: op_ok_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; releasing the selected CS aborts from any state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (low_cnt_s == 8'd1) begin
                    state_s = ST_CMD;
                end else if (low_cnt_s > 8'd1) begin
                    state_s = ST_IGNORE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (rise_v && cnt_r == 8'd7) begin
                    state_s = op_ok_s ? ST_ADDR : ST_IGNORE;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_ADDR: begin
                if (rise_v && cnt_r == addr_last_s) begin
                    if (write_r) begin
                        state_s = ST_WDATA;
                    end else if (quad_r && DUMMY > 0) begin
                        state_s = ST_DUMMY;
                    end else begin
                        state_s = ST_RDATA;
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DUMMY: begin
                if (rise_v && cnt_r == DUMMY_LAST) begin
                    state_s = ST_RDATA;
                end else begin
                    state_s = ST_DUMMY;
                end
            end
            ST_RDATA:  state_s = ST_RDATA;
            ST_WDATA:  state_s = ST_WDATA;
            ST_IGNORE: state_s = ST_IGNORE;
            default:   state_s = ST_IDLE;
        endcase
        if (state_r != ST_IDLE && cs_in[sel_r]) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // FSM output/datapath logic: shifters, counters, read drive staging, write strobes
    always_comb begin
        sel_s       = sel_r;
        cmd_s       = cmd_r;
        cnt_s       = cnt_r;
        addr_s      = addr_r;
        dcnt_s      = dcnt_r;
        wnib_s      = wnib_r;
        quad_s      = quad_r;
        write_s     = write_r;
        drv_sdo_s   = drv_sdo_r;
        drv_oe_s    = drv_oe_r;
        drv_pend_s  = 1'b0;
        err_set_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = {wnib_r, sdi_i};
        case (state_r)
            ST_IDLE: begin
                cnt_s   = 8'd0;
                dcnt_s  = 3'd0;
                quad_s  = 1'b0;
                write_s = 1'b0;
                if (low_cnt_s != 8'd0) begin
                    sel_s = low_idx_s;
                end else begin
                    sel_s = sel_r;
                end
                err_set_s = (low_cnt_s > 8'd1);
            end
            ST_CMD: begin
                if (rise_v) begin
                    cmd_s = cmd_next_s[6:0];
                    if (cnt_r == 8'd7) begin
                        cnt_s     = 8'd0;
                        quad_s    = op_quad_s;
                        write_s   = op_write_s;
                        err_set_s = ~op_ok_s;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cmd_s = cmd_r;
                end
            end
            ST_ADDR: begin
                if (rise_v) begin
                    addr_s = quad_r ? {addr_r[DW-5:0], sdi_i} : {addr_r[DW-2:0], sdi_i[0]};
                    cnt_s  = (cnt_r == addr_last_s) ? 8'd0 : cnt_r + 8'd1;
                end else begin
                    addr_s = addr_r;
                end
            end
            ST_DUMMY: begin
                if (rise_v) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_RDATA: begin
                // Each fall stages the next bit/nibble; the first fall is the prefetch
                if (fall_v) begin
                    drv_pend_s = 1'b1;
                    if (quad_r) begin
                        drv_sdo_s = dcnt_r[0] ? rd_byte_s[3:0] : rd_byte_s[7:4];
                        drv_oe_s  = 4'hF;
                        dcnt_s    = dcnt_r[0] ? 3'd0 : 3'd1;
                        addr_s    = dcnt_r[0] ? addr_r + DW'(1) : addr_r;
                    end else begin
                        drv_sdo_s = {2'b00, rd_byte_s[3'd7 - dcnt_r], 1'b0};
                        drv_oe_s  = 4'b0010;
                        dcnt_s    = dcnt_r + 3'd1;
                        addr_s    = (dcnt_r == 3'd7) ? addr_r + DW'(1) : addr_r;
                    end
                end else begin
                    drv_pend_s = 1'b0;
                end
            end
            ST_WDATA: begin
                if (rise_v) begin
                    if (dcnt_r[0]) begin
                        mem_we_s = 1'b1;
                        addr_s   = addr_r + DW'(1);
                        dcnt_s   = 3'd0;
                    end else begin
                        wnib_s = sdi_i;
                        dcnt_s = 3'd1;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_IGNORE: drv_pend_s = 1'b0;
            default:   drv_pend_s = 1'b0;
        endcase
    end

    // Datapath registers and sticky error
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            sel_r      <= '0;
            cmd_r      <= 7'd0;
            cnt_r      <= 8'd0;
            addr_r     <= '0;
            dcnt_r     <= 3'd0;
            wnib_r     <= 4'd0;
            quad_r     <= 1'b0;
            write_r    <= 1'b0;
            drv_sdo_r  <= 4'd0;
            drv_oe_r   <= 4'd0;
            drv_pend_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            sel_r      <= sel_s;
            cmd_r      <= cmd_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            dcnt_r     <= dcnt_s;
            wnib_r     <= wnib_s;
            quad_r     <= quad_s;
            write_r    <= write_s;
            drv_sdo_r  <= drv_sdo_s;
            drv_oe_r   <= drv_oe_s;
            drv_pend_r <= drv_pend_s;
            err_r      <= err_r | err_set_s;
        end
    end

    // Registered bus drivers; leaving a transaction drops the drive in the same edge
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            sdo_r  <= 4'd0;
            oe_r   <= 4'd0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (state_s == ST_IDLE) begin
                sdo_r <= 4'd0;
                oe_r  <= 4'd0;
            end else if (drv_pend_r) begin
                sdo_r <= drv_sdo_r;
                oe_r  <= drv_oe_r;
            end else begin
                sdo_r <= sdo_r;
                oe_r  <= oe_r;
            end
        end
    end

    // Memory arrays (never reset); the later bus write overrides a colliding backdoor write
    always_ff @(posedge clk_i) begin
        if (rst_in) begin
            if (bd_we_i) begin
                mem_r[bd_sel_i][bd_addr_i] <= bd_data_i;
            end
            if (mem_we_s) begin
                mem_r[sel_r][addr_r] <= mem_wdata_s;
            end
        end
    end

    assign sdo_o    = sdo_r;
    assign sdo_oe_o = oe_r;
    assign busy_o   = busy_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_qspi_mem_model.sv
// Directed self-checking bench for qspi_mem_model; honours QSPI_MEM_WRITE_EN like the design.
`timescale 1ns/1ps
module tb_qspi_mem_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic [1:0]  cs = 2'b11;
    logic [3:0]  sdi = 4'h0;
    logic [3:0]  sdo, sdo_oe;
    logic        bd_we = 1'b0;
    logic [0:0]  bd_sel = 1'b0;
    logic [15:0] bd_addr = 16'h0;
    logic [7:0]  bd_data = 8'h0;
    logic        busy, err;
    int          tests = 0;
    int          errors = 0;
    logic [31:0] rd_val;
    logic [3:0]  first_oe;

    qspi_mem_model dut (
        .clk_i(clk), .rst_in(rst_n), .sck_i(sck), .cs_in(cs), .sdi_i(sdi),
        .sdo_o(sdo), .sdo_oe_o(sdo_oe), .bd_we_i(bd_we), .bd_sel_i(bd_sel),
        .bd_addr_i(bd_addr), .bd_data_i(bd_data), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_pulse(input logic [3:0] d);
        sdi = d;
        sck = 1'b1;
        clk_n(3);
        sck = 1'b0;
        clk_n(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck_pulse({3'b000, b[i]});
    endtask

    task automatic send_addr_single(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) sck_pulse({3'b000, a[i]});
    endtask

    task automatic send_addr_quad(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sck_pulse(a[i*4 +: 4]);
    endtask

    task automatic cs_on(input int idx);
        cs = 2'b11;
        cs[idx] = 1'b0;
        clk_n(2);
    endtask

    task automatic cs_off();
        cs = 2'b11;
        clk_n(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(1);
    endtask

    task automatic bd_write(input logic sel, input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_sel = sel; bd_addr = a; bd_data = d;
        clk_n(1);
        bd_we = 1'b0;
    endtask

    // First bit is already on io1 when the address phase ends
    task automatic read_single(input int dev, input logic [23:0] a, input int nbits,
                               output logic [31:0] v);
        cs_on(dev);
        send_byte(8'h03);
        send_addr_single(a);
        first_oe = sdo_oe;
        v = {31'd0, sdo[1]};
        for (int i = 1; i < nbits; i++) begin
            sck_pulse(4'h0);
            v = {v[30:0], sdo[1]};
        end
        cs_off();
        clk_n(2);
    endtask

    initial begin
        clk_n(3);
        check("rst_sdo", {28'd0, sdo}, 32'h0);
        check("rst_oe", {28'd0, sdo_oe}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        rst_n = 1'b1;
        clk_n(2);

        bd_write(1'b0, 16'h0010, 8'hA5);
        bd_write(1'b0, 16'h0011, 8'h5A);
        bd_write(1'b0, 16'h0012, 8'h3C);
        bd_write(1'b0, 16'h0013, 8'hC3);
        bd_write(1'b0, 16'hFFFF, 8'hAB);
        bd_write(1'b0, 16'h0000, 8'hCD);
        bd_write(1'b0, 16'h0100, 8'h5A);
        bd_write(1'b1, 16'h0020, 8'h7E);
        bd_write(1'b1, 16'h0021, 8'h99);

        // single read with busy tracking
        cs_on(0);
        check("busy_on", {31'd0, busy}, 32'h1);
        send_byte(8'h03);
        send_addr_single(24'h000010);
        check("sr_oe", {28'd0, sdo_oe}, 32'h2);
        rd_val = {31'd0, sdo[1]};
        for (int i = 1; i < 32; i++) begin
            sck_pulse(4'h0);
            rd_val = {rd_val[30:0], sdo[1]};
        end
        check("sr_data", rd_val, 32'hA55A3CC3);
        cs_off();
        check("sr_oe_off", {28'd0, sdo_oe}, 32'h0);
        check("sr_busy_off", {31'd0, busy}, 32'h0);
        clk_n(2);

        // quad read on device 1
        cs_on(1);
        send_byte(8'hEB);
        send_addr_quad(24'h000020);
        for (int i = 0; i < 6; i++) sck_pulse(4'h0);
        check("qr_nib0", {28'd0, sdo}, 32'h7);
        check("qr_oe", {28'd0, sdo_oe}, 32'hF);
        sck_pulse(4'h0);
        check("qr_nib1", {28'd0, sdo}, 32'hE);
        cs_off();
        clk_n(2);

        // quad write across the top of the array
        cs_on(0);
        send_byte(8'h38);
        send_addr_quad(24'h00FFFF);
        sck_pulse(4'h1); sck_pulse(4'h1); sck_pulse(4'h2); sck_pulse(4'h2);
        cs_off();
        clk_n(2);
`ifdef QSPI_MEM_WRITE_EN
        check("wr_err", {31'd0, err}, 32'h0);
        read_single(0, 24'h00FFFF, 16, rd_val);
        check("wr_wrap_data", rd_val, 32'h1122);
`else
        check("wr_err", {31'd0, err}, 32'h1);
        read_single(0, 24'h00FFFF, 16, rd_val);
        check("wr_unchanged", rd_val, 32'hABCD);
`endif

        // reset in the middle of a write byte
        cs_on(0);
        send_byte(8'h38);
        send_addr_quad(24'h000100);
        sck_pulse(4'hF);
        rst_n = 1'b0;
        clk_n(1);
        check("mid_rst_oe", {28'd0, sdo_oe}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        cs = 2'b11;
        clk_n(1);
        rst_n = 1'b1;
        clk_n(2);
        check("mid_rst_err", {31'd0, err}, 32'h0);
        read_single(0, 24'h000100, 8, rd_val);
        check("partial_discard", rd_val, 32'h5A);

        // both chip-selects asserted
        cs = 2'b00;
        clk_n(2);
        send_byte(8'h03);
        sck_pulse(4'h0);
        check("multi_cs_oe", {28'd0, sdo_oe}, 32'h0);
        check("multi_cs_err", {31'd0, err}, 32'h1);
        cs_off();
        clk_n(2);
        do_reset();
        check("err_cleared", {31'd0, err}, 32'h0);

        // unknown opcode
        cs_on(0);
        send_byte(8'h9F);
        sck_pulse(4'h0); sck_pulse(4'h0);
        check("bad_op_oe", {28'd0, sdo_oe}, 32'h0);
        check("bad_op_err", {31'd0, err}, 32'h1);
        cs_off();
        clk_n(2);
        do_reset();
        read_single(0, 24'h000010, 8, rd_val);
        check("post_rst_read", rd_val, 32'hA5);
        check("post_rst_oe", {28'd0, first_oe}, 32'h2);

        // abort after three nibbles of a quad read
        cs_on(1);
        send_byte(8'hEB);
        send_addr_quad(24'h000020);
        for (int i = 0; i < 6; i++) sck_pulse(4'h0);
        sck_pulse(4'h0); sck_pulse(4'h0);
        check("abort_nib2", {28'd0, sdo}, 32'h9);
        cs_off();
        check("abort_oe", {28'd0, sdo_oe}, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        clk_n(2);
        cs_on(1);
        send_byte(8'hEB);
        send_addr_quad(24'h000020);
        for (int i = 0; i < 6; i++) sck_pulse(4'h0);
        check("after_abort_nib", {28'd0, sdo}, 32'h7);
        cs_off();
        clk_n(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/qspi_mem_model.md
# qspi_mem_model

Parametrised, oversampled QSPI memory target for simulation top levels: one instance serves `NCS` chip-selects, each backed by its own `DEPTH`-byte array. It is the flash/PSRAM model for the QSPI bus. It runs on the system clock and detects `sck_i` edges by sampling, so the bench needs no second clock domain. It supports single read (0x03), quad read (0xEB) and, when configured, quad write (0x38). A backdoor port preloads firmware and data.

## Interface
Parameters:
- `NCS`, 2: number of chip-selects/devices.
- `DEPTH`, 65536: bytes per device (power of two).
- `AW`, 24: address bits on the wire.
- `DUMMY`, 6: dummy sck cycles for 0xEB.

Ports:
- `clk_i` input 1: system clock.
- `rst_in` input 1: reset. Synchronous, active-low.
- `sck_i` input 1: QSPI clock. Sampled; high and low phases are each ≥2 `clk_i` cycles.
- `cs_in` input NCS: chip-selects, active-low.
- `sdi_i` input 4: io[3:0] as seen on the bus.
- `sdo_o` output 4: io drive values.
- `sdo_oe_o` output 4: io drive enables.
- `bd_we_i` input 1: backdoor write strobe.
- `bd_sel_i` input $clog2(NCS): backdoor device index.
- `bd_addr_i` input $clog2(DEPTH): backdoor byte address.
- `bd_data_i` input 8: backdoor byte.
- `busy_o` output 1: a transaction is in progress.
- `err_o` output 1: sticky error flag.

## Operation
- Edge detection:
  - `sck_q` is the registered copy of `sck_i`.
  - Rise = `sck_i & ~sck_q`; fall = `~sck_i & sck_q`.
  - Bus inputs are sampled on rise; outputs are changed on fall.
- Transaction start: leaving IDLE requires exactly one `cs_in` bit low. That index is latched as `sel`.
  - If two or more bits are low, the FSM enters IGNORE and sets `err_o`.
- Any `cs_in[sel]` high, in any state, returns the FSM to IDLE on the next `clk_i`. `sdo_oe_o` clears in that same transition.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - CMD: 8 bits on io0, MSB first.
  - 0x03: ADDR takes `AW` single bits on io0, then RDATA single. A bit is driven on io1 only (oe=4'b0010), MSB first, with no dummy cycles.
  - 0xEB: ADDR takes `AW`/4 nibbles on io[3:0], high nibble first. Then DUMMY for `DUMMY` rises, then RDATA quad (oe=4'hF), high nibble first.
  - 0x38: ADDR in quad mode, then WDATA. Nibbles are sampled on rise, and a byte is written after its second nibble.
  - Any other opcode goes to IGNORE and sets `err_o`. IGNORE holds until CS is released.
- Address handling:
  - The effective address is the wire address mod `DEPTH`; upper bits are discarded.
  - The address auto-increments per byte and wraps from `DEPTH`-1 to 0.
- Read prefetch: the first data bit/nibble is driven on the fall that ends ADDR (or DUMMY).
- Backdoor:
  - `bd_we_i` writes `bd_data_i` to `mem[bd_sel_i][bd_addr_i]` at the clock edge.
  - If it collides with a bus write to the same byte, the bus write wins.
  - Backdoor writes are ignored while `rst_in` is low.
- Memory contents are not reset.

## Timing
- Reset values: `sdo_o`=0, `sdo_oe_o`=0, `busy_o`=0, `err_o`=0, FSM in IDLE, `sck_q`=0.
- Registered output latency:
  - `sdo_o` and `sdo_oe_o` change exactly 1 `clk_i` after the cycle in which a fall is detected, i.e. 2 cycles after `sck_i` falls.
  - `busy_o` rises 1 cycle after a valid CS assertion.
  - `busy_o` falls 1 cycle after CS release.
- Read path: a bus write followed by a read of the same address in a later transaction returns the new data.
- Reset mid-transaction: the next cycle shows reset values. A partial write byte is discarded.
- CS releasing in the same cycle as a rise: the rise is ignored.
- `err_o` is cleared only by reset.

## Configuration
- `QSPI_MEM_WRITE_EN` defined: 0x38 is decoded and WDATA is present. This gives PSRAM behaviour.
- `QSPI_MEM_WRITE_EN` undefined: 0x38 is treated as unknown (IGNORE, `err_o`=1) and memory is never bus-modified. This gives flash behaviour. The backdoor port remains functional.

## Test plan
- Single read: backdoor dev0 0x10..0x13 = A5 5A 3C C3; 0x03, addr 0x000010, read 32 bits on io1 -> 0xA55A3CC3, oe=4'b0010.
- Quad read: backdoor dev1 0x20 = 0x7E; CS1 low, 0xEB, addr 0x000020, 6 dummy cycles -> nibbles 7 then E on io[3:0], oe=4'hF.
- Quad write with `QSPI_MEM_WRITE_EN`: 0x38 addr 0x00FFFF, bytes 11 22 -> 0x03 read of 0xFFFF and 0x0000 returns 11 22 (wrap).
  - Without the macro, the same stimulus -> `err_o`=1 and the old contents are unchanged.
- Protocol errors: both CS low -> no drive and `err_o`=1. Opcode 0x9F -> IGNORE, oe=0, `err_o`=1.
  - Reset clears `err_o`; a subsequent 0x03 read succeeds.
- Abort: release CS after 3 nibbles of a 0xEB read -> `sdo_oe_o`=0 within 1 clk and `busy_o`=0. The next transaction decodes normally.
  - Asserting `rst_in` low mid-0x38 -> outputs reset next cycle and the partial byte is not written.
